// File: rtl/alu_result_stage_32.sv
// alu_result_stage_32
// Registered output stage behind the 32-bit ALU. A main entry drives the
// out_* ports. A skid entry catches the one beat that can arrive while main
// is stalled, so in_ready can be a flop without losing throughput.
// zero/neg are derived when a beat is captured and are stored with it.
// Optional build macro: ALU_OVF_COUNT_EN adds a saturating counter of
// accepted overflow beats on ovf_count. Without the macro, ovf_count is tied to 0.
module alu_result_stage_32 #(
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_result,
    input  logic                 in_carry,
    input  logic                 in_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic                 out_zero,
    output logic                 out_neg,
    output logic                 out_carry,
    output logic                 out_overflow,
    input  logic                 sticky_clr,
    output logic                 sticky_ovf,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    typedef struct packed {
        logic [31:0] result;
        logic        carry;
        logic        overflow;
        logic        zero;
        logic        neg;
    } beat_t;

    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  in_ready_q, in_ready_d;
    logic  sticky_q, sticky_d;
    logic  in_xfer;
    logic  out_xfer;
    beat_t in_beat;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = main_valid_q & out_ready;

    // Build the incoming beat, including the flags derived from the result.
    always_comb begin
        in_beat          = '0;
        in_beat.result   = in_result;
        in_beat.carry    = in_carry;
        in_beat.overflow = in_overflow;
        in_beat.zero     = (in_result == 32'd0);
        in_beat.neg      = in_result[31];
    end

    // Steer beats between main and skid so that FIFO order is preserved.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            // in_ready is low while skid is full, so only a drain can happen.
            if (out_xfer) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid_q || out_xfer) begin
                main_d       = in_beat;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
        end
        // Accept more input only while the skid has room after this cycle.
        in_ready_d = ~skid_valid_d;
    end

    // Sticky overflow: a new overflow beat takes priority over a clear.
    always_comb begin
        sticky_d = sticky_q;
        if (in_xfer && in_overflow) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    // State registers. Reset drops both entries and the status.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            sticky_q     <= sticky_d;
        end
    end

`ifdef ALU_OVF_COUNT_EN
    logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

    // Count accepted overflow beats, holding at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (in_xfer && in_overflow && !(&cnt_q)) begin
            cnt_d = cnt_q + OVF_CNT_W'(1);
        end
    end

    // Counter register. Only reset clears it; sticky_clr does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_count = cnt_q;
`else
    assign ovf_count = '0;
`endif

    assign in_ready     = in_ready_q;
    assign out_valid    = main_valid_q;
    assign out_result   = main_q.result;
    assign out_zero     = main_q.zero;
    assign out_neg      = main_q.neg;
    assign out_carry    = main_q.carry;
    assign out_overflow = main_q.overflow;
    assign sticky_ovf   = sticky_q;

endmodule
